ibuffer_extract: RTL and testbench
==================================

IBUFFER_EXTRACT -- requirements
Module: ibuffer_extract

Interface
REQ-001 SHALL have parameter CHUNK_PARCELS, default 8, meaning 16-bit parcels per fetch chunk (one chunk = 16 bytes).
REQ-002 SHALL have parameter LANES, default 4, meaning max instructions delivered per cycle.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all buffered parcels.
REQ-006 SHALL have port enq_valid  input  1  fetch chunk offered.
REQ-007 SHALL have port enq_ready  output  1  chunk accepted when enq_valid & enq_ready.
REQ-008 SHALL have port enq_pc  input  32  chunk base address, 16B-aligned.
REQ-009 SHALL have port enq_parcels  input  CHUNK_PARCELS x 16  parcel data, index 0 at lowest address.
REQ-010 SHALL have port enq_valid_vec  input  CHUNK_PARCELS  per-parcel valid; the bench guarantees one contiguous run of 1s.
REQ-011 SHALL have port deq_valid_vec  output  LANES  per-lane instruction valid, always a lane-0-anchored contiguous run.
REQ-012 SHALL have port deq_instr  output  LANES x 32  instruction bits; compressed lanes zero-extend the parcel.
REQ-013 SHALL have port deq_pc  output  LANES x 32  instruction address.
REQ-014 SHALL have port deq_compressed  output  LANES  1 = 16-bit instruction.
REQ-015 SHALL have port deq_ready  input  1  all valid lanes consumed when deq_ready=1; no partial acceptance.

Function
REQ-016 Storage SHALL be two chunk slots, head and next; each holds the base PC, the parcels and per-parcel valid bits.
REQ-017 A parcel SHALL be uncompressed iff bits [1:0]==2'b11; an uncompressed instruction occupies that parcel and the following one.
REQ-018 enq_ready SHALL equal ~next_slot_valid, driven from registered state only, with no path from deq_ready.
REQ-019 An accepted chunk SHALL be written to head if head is empty after this cycle's dequeue/promotion, else to next.
REQ-020 deq outputs SHALL be combinational from registered state; an enqueued chunk appears on deq outputs the cycle after acceptance.
REQ-021 Extraction SHALL start at the lowest valid head parcel, walk instruction boundaries upward and fill lanes 0..LANES-1 in address order.
REQ-022 Extraction SHALL stop at the first invalid parcel or the end of head, except for a straddle.
REQ-023 Straddle: an uncompressed instruction at head parcel CHUNK_PARCELS-1 SHALL be emitted only if next is valid and next parcel 0 is valid; its upper half is next parcel 0 and deq_pc = head base + 14.
REQ-024 If a straddle has next valid but next parcel 0 invalid, head parcel CHUNK_PARCELS-1 SHALL be dropped silently when deq_ready=1 (redirect case).
REQ-025 If a straddle has next empty, the instruction SHALL be withheld; earlier lanes are still emitted.
REQ-026 An uncompressed instruction whose upper parcel is invalid inside head SHALL terminate extraction and be withheld.
REQ-027 deq_pc SHALL equal slot base + 2 x parcel index, computed mod 2^32.
REQ-028 On deq_ready with any deq lane valid, the consumed parcels' valid bits SHALL clear, including next parcel 0 on a straddle.
REQ-029 When head holds no valid parcels after consumption, next SHALL promote to head in the same edge; enqueue then targets next.
REQ-030 Enqueue and dequeue SHALL occur together in one cycle; with both slots full, dequeue that empties head frees next for the following cycle's enq_ready.
REQ-031 flush SHALL clear all valid bits at the edge, overriding enq and deq in that cycle; enq_ready SHALL be 1 the following cycle.
REQ-032 With deq_ready=0, state SHALL hold and deq outputs SHALL remain stable.

Reset
REQ-033 While RST=1, all slot and parcel valid bits SHALL clear asynchronously, giving deq_valid_vec=0 and enq_ready=1.
REQ-034 Data and PC registers SHALL need no reset; X values SHALL NOT reach deq outputs for lanes where deq_valid_vec is 0.
REQ-035 Deassertion of RST mid-stream SHALL leave the block empty, with no chunk accepted during reset.

Verification
REQ-036 Scenario 1: chunk at pc 0x1000, all 8 parcels compressed, deq_ready=1 -> cycle+1 lanes 1111 at pcs 0x1000-0x1006; cycle+2 lanes 1111 at 0x1008-0x100E; head empty.
REQ-037 Scenario 2: parcels alternate uncompressed pairs (4 x 32-bit) -> one cycle: lanes 1111, deq_compressed=0000, pcs 0x1000/04/08/0C.
REQ-038 Scenario 3: head parcel 7 uncompressed with next absent -> instruction withheld; next chunk at 0x1010 arrives -> lane 0 pc 0x100E, instr = {next p0, head p7}; next p0 consumed.
REQ-039 Scenario 4: enq_valid_vec=11110000 (entry at offset 4) -> first lane pc = base+8.
REQ-040 Scenario 5: both slots full, deq_ready=0 -> enq_ready=0 and outputs stable; flush -> cycle+1 deq_valid_vec=0, enq_ready=1.
REQ-041 Scenario 6: RST asserted while both slots are valid mid-extraction -> deq_valid_vec=0 and enq_ready=1 immediately, without a clock edge.

Source files
------------

// File: rtl/ibuffer_extract_if.sv
// Fetch-chunk enqueue and instruction-lane dequeue bundle for the instruction buffer.
// master drives chunks and deq_ready; slave is the buffer itself.
interface ibuffer_extract_if #(
  parameter int unsigned CHUNK_PARCELS = 8,
  parameter int unsigned LANES         = 4
);
  logic                           enq_valid;
  logic                           enq_ready;
  logic [31:0]                    enq_pc;
  logic [CHUNK_PARCELS-1:0][15:0] enq_parcels;
  logic [CHUNK_PARCELS-1:0]       enq_valid_vec;
  logic [LANES-1:0]               deq_valid_vec;
  logic [LANES-1:0][31:0]         deq_instr;
  logic [LANES-1:0][31:0]         deq_pc;
  logic [LANES-1:0]               deq_compressed;
  logic                           deq_ready;

  modport master (
    output enq_valid, enq_pc, enq_parcels, enq_valid_vec, deq_ready,
    input  enq_ready, deq_valid_vec, deq_instr, deq_pc, deq_compressed
  );

  modport slave (
    input  enq_valid, enq_pc, enq_parcels, enq_valid_vec, deq_ready,
    output enq_ready, deq_valid_vec, deq_instr, deq_pc, deq_compressed
  );
endinterface

// File: rtl/ibuffer_extract.sv
// Two-slot (head/next) fetch-chunk buffer that carves up to LANES mixed 16/32-bit
// instructions per cycle out of head, borrowing next parcel 0 for a straddling instruction.
module ibuffer_extract #(
  parameter int unsigned CHUNK_PARCELS = 8,
  parameter int unsigned LANES         = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  ibuffer_extract_if.slave bus
);
  localparam int unsigned IW    = $clog2(CHUNK_PARCELS);
  localparam logic [IW:0] NP    = (IW+1)'(CHUNK_PARCELS);
  localparam logic [IW:0] LASTP = (IW+1)'(CHUNK_PARCELS - 1);

  logic [31:0]                    head_pc, next_pc;
  logic [CHUNK_PARCELS-1:0][15:0] head_par, next_par;
  logic [CHUNK_PARCELS-1:0]       head_vld, next_vld, head_vld_d, next_vld_d;
  logic [CHUNK_PARCELS-1:0]       take_h, head_left, next_left;
  logic                           take_n0, next_any, accept, promote, enq_head, enq_next;
  logic [IW:0]                    pos;
  logic [IW-1:0]                  idx, idx1;
  logic [15:0]                    lo;
  logic                           stop;

  assign next_any      = |next_vld;
  assign bus.enq_ready = ~next_any;

  // Walk instruction boundaries from the lowest valid head parcel; take_h marks
  // every head parcel retired on deq_ready, including a dropped redirect straddle.
  always_comb begin
    bus.deq_valid_vec  = '0;
    bus.deq_instr      = '0;
    bus.deq_pc         = '0;
    bus.deq_compressed = '0;
    take_h  = '0;
    take_n0 = 1'b0;
    stop    = 1'b0;
    idx     = '0;
    idx1    = '0;
    lo      = '0;
    pos     = NP;
    for (int unsigned i = CHUNK_PARCELS; i > 0; i--) begin
      if (head_vld[i-1]) pos = (IW+1)'(i - 1);
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      if (!stop && pos < NP && head_vld[pos[IW-1:0]]) begin
        idx  = pos[IW-1:0];
        idx1 = idx + IW'(1);
        lo   = head_par[idx];
        if (lo[1:0] != 2'b11) begin
          bus.deq_valid_vec[l]  = 1'b1;
          bus.deq_compressed[l] = 1'b1;
          bus.deq_instr[l]      = {16'h0000, lo};
          bus.deq_pc[l]         = head_pc + {{(31-IW){1'b0}}, idx, 1'b0};
          take_h[idx]           = 1'b1;
          pos                   = pos + (IW+1)'(1);
        end else if (pos != LASTP) begin
          if (head_vld[idx1]) begin
            bus.deq_valid_vec[l] = 1'b1;
            bus.deq_instr[l]     = {head_par[idx1], lo};
            bus.deq_pc[l]        = head_pc + {{(31-IW){1'b0}}, idx, 1'b0};
            take_h[idx]          = 1'b1;
            take_h[idx1]         = 1'b1;
            pos                  = pos + (IW+1)'(2);
          end else begin
            stop = 1'b1;
          end
        end else if (next_any && next_vld[0]) begin
          bus.deq_valid_vec[l] = 1'b1;
          bus.deq_instr[l]     = {next_par[0], lo};
          bus.deq_pc[l]        = head_pc + {{(31-IW){1'b0}}, idx, 1'b0};
          take_h[idx]          = 1'b1;
          take_n0              = 1'b1;
          pos                  = pos + (IW+1)'(1);
          stop                 = 1'b1;
        end else begin
          // next present without parcel 0 means fetch redirected: discard the half instruction
          if (next_any) take_h[idx] = 1'b1;
          stop = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    head_left = head_vld;
    next_left = next_vld;
    if (bus.deq_ready) begin
      head_left    = head_vld & ~take_h;
      next_left[0] = next_vld[0] & ~take_n0;
    end
    promote  = ~|head_left & |next_left;
    accept   = bus.enq_valid & bus.enq_ready;
    enq_head = accept & ~|head_left & ~promote;
    enq_next = accept & ~enq_head;
    head_vld_d = promote ? next_left : head_left;
    next_vld_d = promote ? '0 : next_left;
    if (enq_head) head_vld_d = bus.enq_valid_vec;
    if (enq_next) next_vld_d = bus.enq_valid_vec;
    if (flush) begin
      head_vld_d = '0;
      next_vld_d = '0;
      promote    = 1'b0;
      enq_head   = 1'b0;
      enq_next   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_vld <= '0;
      next_vld <= '0;
    end else begin
      head_vld <= head_vld_d;
      next_vld <= next_vld_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_head) begin
      head_pc  <= bus.enq_pc;
      head_par <= bus.enq_parcels;
    end else if (promote) begin
      head_pc  <= next_pc;
      head_par <= next_par;
    end
    if (enq_next) begin
      next_pc  <= bus.enq_pc;
      next_par <= bus.enq_parcels;
    end
  end
endmodule

// File: tb/tb_ibuffer_extract.sv
// Bench for ibuffer_extract: directed scenarios plus randomized traffic against a
// queue-of-parcels reference model.
module tb_ibuffer_extract;
  localparam int unsigned CP = 8;
  localparam int unsigned LN = 4;
  typedef logic [CP-1:0][15:0] chunk_t;
  typedef struct { logic [31:0] pc; logic [15:0] d; } parcel_t;

  logic clk, rst, flush;
  int   n_cmp = 0;
  int   n_bad = 0;

  ibuffer_extract_if #(.CHUNK_PARCELS(CP), .LANES(LN)) bus ();
  ibuffer_extract #(.CHUNK_PARCELS(CP), .LANES(LN)) dut (
    .CLK(clk), .RST(rst), .flush(flush), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: valid parcels of each slot in address order.
  parcel_t           hq[$];
  parcel_t           nq[$];
  logic [31:0]       nbase;
  logic [LN-1:0]     exp_v, exp_c;
  logic [LN-1:0][31:0] exp_i, exp_p;
  int                take_h;
  bit                take_n;

  function automatic void model_eval();
    int k = 0;
    bit drop = 0;
    exp_v = '0; exp_c = '0; exp_i = '0; exp_p = '0; take_n = 0;
    for (int l = 0; l < LN; l++) begin
      if (k >= hq.size()) break;
      if (hq[k].d[1:0] != 2'b11) begin
        exp_v[l] = 1'b1; exp_c[l] = 1'b1; exp_i[l] = {16'h0, hq[k].d}; exp_p[l] = hq[k].pc;
        k++;
      end else if (hq[k].pc[3:0] != 4'hE) begin
        if (k + 1 >= hq.size()) break;
        exp_v[l] = 1'b1; exp_i[l] = {hq[k+1].d, hq[k].d}; exp_p[l] = hq[k].pc;
        k += 2;
      end else if (nq.size() > 0 && nq[0].pc == nbase) begin
        exp_v[l] = 1'b1; exp_i[l] = {nq[0].d, hq[k].d}; exp_p[l] = hq[k].pc;
        k++; take_n = 1;
        break;
      end else begin
        if (nq.size() > 0) drop = 1;
        break;
      end
    end
    take_h = k + int'(drop);
  endfunction

  function automatic void model_apply(input bit ev, input logic [31:0] pc, input chunk_t par,
                                      input logic [CP-1:0] vv, input bit dr, input bit fl);
    parcel_t q[$];
    bit acc;
    if (fl) begin
      hq.delete(); nq.delete();
      return;
    end
    acc = ev && (nq.size() == 0);
    if (dr) begin
      for (int i = 0; i < take_h; i++) hq.delete(0);
      if (take_n) nq.delete(0);
    end
    if (hq.size() == 0 && nq.size() != 0) begin
      hq = nq; nq.delete();
    end
    if (acc) begin
      for (int j = 0; j < CP; j++) if (vv[j]) q.push_back('{pc + 32'(2*j), par[j]});
      if (hq.size() == 0) hq = q;
      else begin nq = q; nbase = pc; end
    end
  endfunction

  task automatic tick(input bit ev, input logic [31:0] pc, input chunk_t par,
                      input logic [CP-1:0] vv, input bit dr, input bit fl);
    bus.enq_valid = ev; bus.enq_pc = pc; bus.enq_parcels = par;
    bus.enq_valid_vec = vv; bus.deq_ready = dr; flush = fl;
    model_eval();
    @(posedge clk);
    model_apply(ev, pc, par, vv, dr, fl);
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_parcels = '0;
    bus.enq_valid_vec = '0; bus.deq_ready = 1'b0;
    hq.delete(); nq.delete();
    #12;
    n_cmp++; if (bus.deq_valid_vec !== 4'b0000) begin n_bad++; $display("FAIL reset_valid: got %b want 0000", bus.deq_valid_vec); end
    n_cmp++; if (bus.enq_ready !== 1'b1) begin n_bad++; $display("FAIL reset_enq_ready: got %b want 1", bus.enq_ready); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_compressed();
    chunk_t par;
    for (int j = 0; j < CP; j++) par[j] = {8'(j), 8'h11};
    tick(0, '0, '0, '0, 0, 1);
    tick(1, 32'h1000, par, 8'hFF, 1, 0);
    for (int c = 0; c < 2; c++) begin
      n_cmp++; if (bus.deq_valid_vec !== 4'b1111) begin n_bad++; $display("FAIL s1_valid%0d: got %b want 1111", c, bus.deq_valid_vec); end
      n_cmp++; if (bus.deq_compressed !== 4'b1111) begin n_bad++; $display("FAIL s1_comp%0d: got %b want 1111", c, bus.deq_compressed); end
      for (int l = 0; l < LN; l++) begin
        n_cmp++;
        if (bus.deq_pc[l] !== 32'h1000 + 32'(8*c + 2*l) || bus.deq_instr[l] !== {16'h0, 8'(4*c + l), 8'h11}) begin
          n_bad++; $display("FAIL s1_lane%0d_%0d: got pc %h instr %h want pc %h", c, l, bus.deq_pc[l], bus.deq_instr[l], 32'h1000 + 32'(8*c + 2*l));
        end
      end
      tick(0, '0, '0, '0, 1, 0);
    end
    n_cmp++; if (bus.deq_valid_vec !== 4'b0000) begin n_bad++; $display("FAIL s1_empty: got %b want 0000", bus.deq_valid_vec); end
  endtask

  task automatic test_uncompressed();
    chunk_t par;
    for (int j = 0; j < CP/2; j++) begin
      par[2*j] = {8'(j), 8'hA3}; par[2*j+1] = {8'(j), 8'h5C};
    end
    tick(0, '0, '0, '0, 0, 1);
    tick(1, 32'h1000, par, 8'hFF, 1, 0);
    n_cmp++; if (bus.deq_valid_vec !== 4'b1111) begin n_bad++; $display("FAIL s2_valid: got %b want 1111", bus.deq_valid_vec); end
    n_cmp++; if (bus.deq_compressed !== 4'b0000) begin n_bad++; $display("FAIL s2_comp: got %b want 0000", bus.deq_compressed); end
    for (int l = 0; l < LN; l++) begin
      n_cmp++;
      if (bus.deq_pc[l] !== 32'h1000 + 32'(4*l) || bus.deq_instr[l] !== {8'(l), 8'h5C, 8'(l), 8'hA3}) begin
        n_bad++; $display("FAIL s2_lane%0d: got pc %h instr %h want pc %h", l, bus.deq_pc[l], bus.deq_instr[l], 32'h1000 + 32'(4*l));
      end
    end
    tick(0, '0, '0, '0, 1, 0);
    n_cmp++; if (bus.deq_valid_vec !== 4'b0000) begin n_bad++; $display("FAIL s2_empty: got %b want 0000", bus.deq_valid_vec); end
  endtask

  task automatic test_straddle();
    chunk_t h, n;
    h = '0; h[7] = 16'h5A57;
    n[0] = 16'hC0DE;
    for (int j = 1; j < CP; j++) n[j] = {8'(j), 8'h21};
    tick(0, '0, '0, '0, 0, 1);
    tick(1, 32'h1000, h, 8'h80, 1, 0);
    tick(0, '0, '0, '0, 1, 0);
    n_cmp++; if (bus.deq_valid_vec !== 4'b0000) begin n_bad++; $display("FAIL s3_withheld: got %b want 0000", bus.deq_valid_vec); end
    tick(1, 32'h1010, n, 8'hFF, 0, 0);
    n_cmp++; if (bus.deq_valid_vec !== 4'b0001) begin n_bad++; $display("FAIL s3_valid: got %b want 0001", bus.deq_valid_vec); end
    n_cmp++;
    if (bus.deq_pc[0] !== 32'h100E || bus.deq_instr[0] !== 32'hC0DE5A57 || bus.deq_compressed[0] !== 1'b0) begin
      n_bad++; $display("FAIL s3_lane0: got pc %h instr %h comp %b want pc 0000100e instr c0de5a57 comp 0", bus.deq_pc[0], bus.deq_instr[0], bus.deq_compressed[0]);
    end
    tick(0, '0, '0, '0, 1, 0);
    n_cmp++; if (bus.deq_valid_vec !== 4'b1111) begin n_bad++; $display("FAIL s3_promote_valid: got %b want 1111", bus.deq_valid_vec); end
    n_cmp++;
    if (bus.deq_pc[0] !== 32'h1012 || bus.deq_instr[0] !== 32'h00000121) begin
      n_bad++; $display("FAIL s3_p0_consumed: got pc %h instr %h want pc 00001012 instr 00000121", bus.deq_pc[0], bus.deq_instr[0]);
    end
    n_cmp++; if (bus.enq_ready !== 1'b1) begin n_bad++; $display("FAIL s3_enq_ready: got %b want 1", bus.enq_ready); end
  endtask

  task automatic test_offset_entry();
    chunk_t par;
    for (int j = 0; j < CP; j++) par[j] = {8'(j), 8'h41};
    tick(0, '0, '0, '0, 0, 1);
    tick(1, 32'h2000, par, 8'hF0, 0, 0);
    n_cmp++; if (bus.deq_valid_vec !== 4'b1111) begin n_bad++; $display("FAIL s4_valid: got %b want 1111", bus.deq_valid_vec); end
    n_cmp++;
    if (bus.deq_pc[0] !== 32'h2008 || bus.deq_instr[0] !== 32'h00000441 || bus.deq_pc[3] !== 32'h200E) begin
      n_bad++; $display("FAIL s4_pc: got pc0 %h instr0 %h pc3 %h want 00002008 00000441 0000200e", bus.deq_pc[0], bus.deq_instr[0], bus.deq_pc[3]);
    end
  endtask

  task automatic test_full_flush();
    chunk_t par;
    for (int j = 0; j < CP; j++) par[j] = {8'(j), 8'h01};
    tick(0, '0, '0, '0, 0, 1);
    tick(1, 32'h3000, par, 8'hFF, 0, 0);
    tick(1, 32'h3010, par, 8'hFF, 0, 0);
    for (int c = 0; c < 2; c++) begin
      n_cmp++; if (bus.enq_ready !== 1'b0) begin n_bad++; $display("FAIL s5_full%0d: got enq_ready %b want 0", c, bus.enq_ready); end
      n_cmp++;
      if (bus.deq_valid_vec !== 4'b1111 || bus.deq_pc[0] !== 32'h3000 || bus.deq_pc[3] !== 32'h3006) begin
        n_bad++; $display("FAIL s5_hold%0d: got valid %b pc0 %h pc3 %h want 1111 00003000 00003006", c, bus.deq_valid_vec, bus.deq_pc[0], bus.deq_pc[3]);
      end
      tick(1, 32'h4000, par, 8'hFF, 0, 0);
    end
    tick(1, 32'h5000, par, 8'hFF, 1, 1);
    n_cmp++; if (bus.deq_valid_vec !== 4'b0000) begin n_bad++; $display("FAIL s5_flush_valid: got %b want 0000", bus.deq_valid_vec); end
    n_cmp++; if (bus.enq_ready !== 1'b1) begin n_bad++; $display("FAIL s5_flush_ready: got %b want 1", bus.enq_ready); end
    tick(0, '0, '0, '0, 1, 0);
    n_cmp++; if (bus.deq_valid_vec !== 4'b0000) begin n_bad++; $display("FAIL s5_flush_noenq: got %b want 0000", bus.deq_valid_vec); end
  endtask

  task automatic rand_chunk(output logic [31:0] pc, output chunk_t par, output logic [CP-1:0] vv);
    logic [31:0] r;
    int unsigned s, e;
    r  = $urandom();
    pc = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF0 : {r[31:4], 4'h0};
    s  = $urandom_range(1, 0) ? 0 : $urandom_range(CP-1, 0);
    e  = $urandom_range(1, 0) ? CP-1 : $urandom_range(CP-1, s);
    vv = '0;
    for (int unsigned j = s; j <= e; j++) vv[j] = 1'b1;
    for (int j = 0; j < CP; j++) begin
      r = $urandom();
      par[j] = r[15:0];
      if ($urandom_range(1, 0)) par[j][1:0] = 2'b11;
      else if (r[1:0] == 2'b11) par[j][1:0] = 2'b01;
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    chunk_t par;
    logic [CP-1:0] vv;
    tick(0, '0, '0, '0, 0, 1);
    for (int c = 0; c < 600; c++) begin
      rand_chunk(pc, par, vv);
      tick($urandom_range(9, 0) < 7, pc, par, vv, $urandom_range(9, 0) < 6, $urandom_range(49, 0) == 0);
      n_cmp++; if (bus.enq_ready !== (nq.size() == 0)) begin n_bad++; $display("FAIL rnd_enq_ready@%0d: got %b want %b", c, bus.enq_ready, nq.size() == 0); end
      n_cmp++; if (bus.deq_valid_vec !== exp_v) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, bus.deq_valid_vec, exp_v); end
      for (int l = 0; l < LN; l++) begin
        if (exp_v[l]) begin
          n_cmp++;
          if ({bus.deq_instr[l], bus.deq_pc[l], bus.deq_compressed[l]} !== {exp_i[l], exp_p[l], exp_c[l]}) begin
            n_bad++; $display("FAIL rnd_lane%0d@%0d: got instr %h pc %h comp %b want instr %h pc %h comp %b", l, c,
                              bus.deq_instr[l], bus.deq_pc[l], bus.deq_compressed[l], exp_i[l], exp_p[l], exp_c[l]);
          end
        end
      end
      n_cmp++; if ($isunknown({bus.deq_instr, bus.deq_pc, bus.deq_compressed})) begin n_bad++; $display("FAIL rnd_xprop@%0d: got unknown bits want none", c); end
    end
  endtask

  task automatic test_async_reset();
    chunk_t par;
    for (int j = 0; j < CP; j++) par[j] = {8'(j), 8'h31};
    tick(0, '0, '0, '0, 0, 1);
    tick(1, 32'h6000, par, 8'hFF, 0, 0);
    tick(1, 32'h6010, par, 8'hFF, 1, 0);
    n_cmp++;
    if (bus.deq_valid_vec !== 4'b1111 || bus.enq_ready !== 1'b0 || bus.deq_pc[0] !== 32'h6008) begin
      n_bad++; $display("FAIL s6_pre: got valid %b enq_ready %b pc0 %h want 1111 0 00006008", bus.deq_valid_vec, bus.enq_ready, bus.deq_pc[0]);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.deq_valid_vec !== 4'b0000) begin n_bad++; $display("FAIL s6_async_valid: got %b want 0000", bus.deq_valid_vec); end
    n_cmp++; if (bus.enq_ready !== 1'b1) begin n_bad++; $display("FAIL s6_async_ready: got %b want 1", bus.enq_ready); end
    bus.enq_valid = 1'b1; bus.enq_pc = 32'h7000; bus.enq_valid_vec = 8'hFF; bus.deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hq.delete(); nq.delete();
    tick(0, '0, '0, '0, 0, 0);
    n_cmp++; if (bus.deq_valid_vec !== 4'b0000) begin n_bad++; $display("FAIL s6_post_valid: got %b want 0000", bus.deq_valid_vec); end
    n_cmp++; if (bus.enq_ready !== 1'b1) begin n_bad++; $display("FAIL s6_post_ready: got %b want 1", bus.enq_ready); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_compressed();
    test_uncompressed();
    test_straddle();
    test_offset_entry();
    test_full_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
